lsu_ctrl: RTL and testbench

- Load/store initiator between the RV32I execute stage and the byte-addressable data memory.
- Computes the effective address, checks alignment, range and funct3 legality, and issues word-wide accesses to the memory.
- Does sign/zero extension of loads locally.
- Performs SB/SH as a read-modify-write of the aligned word, so the memory's sub-word write behaviour is never relied on.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_ctrl_if.sv | 39 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e  - controller FSM states (also exported on the debug port)
//   byte_mask_e  - RV32I load/store width encodings, same values as the
//                  data memory's byte_mask field
//   resp_cause_e - response status codes
//   MASK_WORD    - the only mask the controller ever presents to memory
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    typedef enum logic [2:0] {
        MASK_B  = 3'b000,
        MASK_H  = 3'b001,
        MASK_W  = 3'b010,
        MASK_BU = 3'b100,
        MASK_HU = 3'b101
    } byte_mask_e;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } resp_cause_e;

    localparam logic [2:0] MASK_WORD = 3'b010;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        end
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the core request/response and data-memory signals.
//   slave  - the LSU side (lsu_ctrl)
//   master - the environment side (core + data memory)
// Handshake: a request is transferred on a rising edge where
// req_valid && req_ready. req_ready is high only while the LSU is idle;
// the core must hold req_* stable until that edge. resp_valid is a
// single-cycle pulse with no backpressure. mem_rdata is valid the cycle
// after mem_addr is sampled; mem_wen is a one-cycle write strobe.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_byte_mask;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_cause, mem_addr,
               mem_wdata, mem_byte_mask, mem_wen
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_cause, mem_addr,
               mem_wdata, mem_byte_mask, mem_wen
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte/half lane handling.
//   rd_word_i    - aligned word read from memory
//   offset_i     - byte offset ea[1:0]
//   funct3_i     - RV32I width/sign encoding
//   wdata_i      - low half of the store data (rs2[15:0])
//   load_data_o  - selected lane, sign- or zero-extended
//   store_data_o - rd_word_i with the addressed byte/half replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word_i[7:0];
        case (offset_i)
            2'd0: byte_sel = rd_word_i[7:0];
            2'd1: byte_sel = rd_word_i[15:8];
            2'd2: byte_sel = rd_word_i[23:16];
            2'd3: byte_sel = rd_word_i[31:24];
            default: byte_sel = rd_word_i[7:0];
        endcase
        half_sel = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        load_data_o = rd_word_i;
        case (funct3_i)
            MASK_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MASK_BU: load_data_o = {24'h0, byte_sel};
            MASK_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
            MASK_HU: load_data_o = {16'h0, half_sel};
            default: load_data_o = rd_word_i;
        endcase
    end

    always_comb begin
        store_data_o = rd_word_i;
        case (funct3_i[1:0])
            2'b00: begin
                case (offset_i)
                    2'd0: store_data_o[7:0]   = wdata_i[7:0];
                    2'd1: store_data_o[15:8]  = wdata_i[7:0];
                    2'd2: store_data_o[23:16] = wdata_i[7:0];
                    2'd3: store_data_o[31:24] = wdata_i[7:0];
                    default: store_data_o = rd_word_i;
                endcase
            end
            2'b01: begin
                if (offset_i[1]) store_data_o[31:16] = wdata_i;
                else             store_data_o[15:0]  = wdata_i;
            end
            default: store_data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store initiator toward a word-wide data memory.
// Computes ea = base + offset, checks funct3 legality, alignment and
// range, then issues word accesses. Sub-word stores are done as
// read-modify-write so the memory only ever sees full-word writes.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - request/response/memory bundle (slave modport)
//   state_o    - current FSM state, for observation only
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WORDS = 128
)(
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus,
    output lsu_state_e  state_o
);

    lsu_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wen_q, mem_wen_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    resp_cause_e cause_q, cause_d;

    logic [31:0] ea;
    logic        misaligned;
    logic        out_of_range;
    resp_cause_e req_cause;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign ea = bus.req_base + bus.req_offset;

    always_comb begin
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && ea[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        out_of_range = (ea[31:2] >= 30'(WORDS));
        if (funct3_illegal(bus.req_is_store, bus.req_funct3)) req_cause = CAUSE_ILLEGAL;
        else if (misaligned)                                  req_cause = CAUSE_MISALIGN;
        else if (out_of_range)                                req_cause = CAUSE_RANGE;
        else                                                  req_cause = CAUSE_OK;
    end

    lsu_align u_align (
        .rd_word_i    (bus.mem_rdata),
        .offset_i     (offset_q),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wen_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        cause_d      = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    is_store_d   = bus.req_is_store;
                    funct3_d     = bus.req_funct3;
                    offset_d     = ea[1:0];
                    wdata_d      = bus.req_wdata[15:0];
                    resp_rdata_d = 32'h0;
                    cause_d      = req_cause;
                    if (req_cause != CAUSE_OK) begin
                        // Faults never touch the memory interface.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        mem_addr_d = {ea[31:2], 2'b00};
                        if (bus.req_is_store && bus.req_funct3 == MASK_W) begin
                            state_d     = ST_WR;
                            mem_wdata_d = bus.req_wdata;
                            mem_wen_d   = 1'b1;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (is_store_q) begin
                    // Merged word is ready in MERGE and held through WR.
                    state_d     = ST_MERGE;
                    mem_wdata_d = store_data;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = load_data;
                    resp_valid_d = 1'b1;
                end
            end
            ST_MERGE: begin
                state_d   = ST_WR;
                mem_wen_d = 1'b1;
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            wdata_q      <= 16'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            cause_q      <= CAUSE_OK;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wen_q    <= mem_wen_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            cause_q      <= cause_d;
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_cause    = cause_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_byte_mask = MASK_WORD;
    assign bus.mem_wen       = mem_wen_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_resp_cyc = 0;

    lsu_ctrl_if bus ();
    lsu_state_e state_o;

    lsu_ctrl #(.WORDS(128)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- data memory model ----------------
    logic [31:0] mem [0:127];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_idx = 7'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (bus.mem_wen) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [1:0]  exp_cause_q[$];
    int          exp_lat_q[$];
    int          acc_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                last_resp_cyc = cyc;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    check("resp_rdata", bus.resp_rdata, exp_q.pop_front());
                    check("resp_cause", {30'h0, bus.resp_cause}, {30'h0, exp_cause_q.pop_front()});
                    check("resp_latency", cyc - acc_q.pop_front() + 1, exp_lat_q.pop_front());
                end
            end
            if (bus.mem_wen) begin
                check("wr_mask", {29'h0, bus.mem_byte_mask}, 32'h2);
                if (wr_addr_q.size() == 0) begin
                    check("unexpected_wen", 32'd1, 32'd0);
                end else begin
                    check("wr_addr", bus.mem_addr, wr_addr_q.pop_front());
                    check("wr_data", bus.mem_wdata, wr_data_q.pop_front());
                end
            end
            if (state_o == ST_RD) begin
                if (exp_addr_q.size() == 0) check("unexpected_rd", 32'd1, 32'd0);
                else                         check("rd_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic exp_resp,
                         input logic [31:0] exp_rd, input logic [1:0] exp_c,
                         input int lat, input logic rd_en, input logic wr_en,
                         input logic [31:0] addr, output int acc_cyc);
        int waited;
        waited = 0;
        acc_cyc = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_resp) begin
            exp_q.push_back(exp_rd);
            exp_cause_q.push_back(exp_c);
            exp_lat_q.push_back(lat);
        end
        if (rd_en) exp_addr_q.push_back(addr);
        if (wr_en) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(exp_rd_wdata(st, wd, addr));
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (exp_resp) acc_q.push_back(cyc);
        bus.req_valid = 1'b0;
    endtask

    // Expected written word: supplied directly by the caller via wd_exp.
    logic [31:0] wd_exp = 32'h0;
    function automatic logic [31:0] exp_rd_wdata(input logic st, input logic [31:0] wd, input logic [31:0] addr);
        return wd_exp;
    endfunction

    // ---------------- stimulus ----------------
    int acc;
    int waited;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_base     = 32'h0;
        bus.req_offset   = 32'h0;
        bus.req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'h0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_cause", {30'h0, bus.resp_cause}, 32'd0);
        check("rst_mem_addr",   bus.mem_addr, 32'h0);
        check("rst_mem_wdata",  bus.mem_wdata, 32'h0);
        check("rst_mem_mask",   {29'h0, bus.mem_byte_mask}, 32'h2);
        check("rst_mem_wen",    {31'h0, bus.mem_wen}, 32'd0);
        rst_n = 1'b1;

        preload(7'd4, 32'h8899AABB);

        // 1: byte loads, sign and zero extended
        issue(1'b0, 3'b000, 32'h10, 32'd3, 32'h0, 1'b1, 32'hFFFFFF88, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        issue(1'b0, 3'b100, 32'h10, 32'd3, 32'h0, 1'b1, 32'h00000088, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        issue(1'b0, 3'b000, 32'h10, 32'd0, 32'h0, 1'b1, 32'hFFFFFFBB, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        // 2: half loads with negative offset
        issue(1'b0, 3'b001, 32'h14, 32'hFFFFFFFE, 32'h0, 1'b1, 32'hFFFF8899, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        issue(1'b0, 3'b101, 32'h14, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h00008899, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        issue(1'b0, 3'b101, 32'h10, 32'd0, 32'h0, 1'b1, 32'h0000AABB, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        // 3: SB read-modify-write, then read back
        wd_exp = 32'h889977BB;
        issue(1'b1, 3'b000, 32'h10, 32'd1, 32'h12345677, 1'b1, 32'h0, 2'd0, 5, 1'b1, 1'b1, 32'h10, acc);
        issue(1'b0, 3'b010, 32'h10, 32'd0, 32'h0, 1'b1, 32'h889977BB, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        // SH upper half
        wd_exp = 32'hCAFE77BB;
        issue(1'b1, 3'b001, 32'h10, 32'd2, 32'h1234CAFE, 1'b1, 32'h0, 2'd0, 5, 1'b1, 1'b1, 32'h10, acc);
        issue(1'b0, 3'b010, 32'h10, 32'd0, 32'h0, 1'b1, 32'hCAFE77BB, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);
        // 4: faults and their priority
        issue(1'b0, 3'b010, 32'h10, 32'd2, 32'h0, 1'b1, 32'h0, 2'd1, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b1, 3'b010, 32'h200, 32'd0, 32'h55, 1'b1, 32'h0, 2'd2, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b0, 3'b011, 32'h10, 32'd0, 32'h0, 1'b1, 32'h0, 2'd3, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b1, 3'b100, 32'h10, 32'd0, 32'h0, 1'b1, 32'h0, 2'd3, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b0, 3'b111, 32'h201, 32'd0, 32'h0, 1'b1, 32'h0, 2'd3, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b0, 3'b010, 32'h203, 32'd0, 32'h0, 1'b1, 32'h0, 2'd1, 1, 1'b0, 1'b0, 32'h0, acc);
        issue(1'b1, 3'b001, 32'h11, 32'd0, 32'h0, 1'b1, 32'h0, 2'd1, 1, 1'b0, 1'b0, 32'h0, acc);

        // 5: reset during WAIT of an SH
        repeat (4) @(negedge clk);
        preload(7'd4, 32'h8899AABB);
        issue(1'b1, 3'b001, 32'h10, 32'd0, 32'h0000CAFE, 1'b0, 32'h0, 2'd0, 0, 1'b1, 1'b0, 32'h10, acc);
        waited = 0;
        @(negedge clk);
        while (state_o != ST_WAIT && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("reach_wait", {29'h0, state_o}, {29'h0, ST_WAIT});
        rst_n = 1'b0;
        #1;
        check("midrst_wen",   {31'h0, bus.mem_wen}, 32'd0);
        check("midrst_state", {29'h0, state_o}, {29'h0, ST_IDLE});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_ready", {31'h0, bus.req_ready}, 32'd1);
        check("postrst_word",  mem[4], 32'h8899AABB);
        issue(1'b0, 3'b010, 32'h10, 32'd0, 32'h0, 1'b1, 32'h8899AABB, 2'd0, 3, 1'b1, 1'b0, 32'h10, acc);

        // 6: SW at the top word, then back-to-back LW
        wd_exp = 32'hDEADBEEF;
        issue(1'b1, 3'b010, 32'h1FC, 32'd0, 32'hDEADBEEF, 1'b1, 32'h0, 2'd0, 2, 1'b0, 1'b1, 32'h1FC, acc);
        issue(1'b0, 3'b010, 32'h1F0, 32'd12, 32'h0, 1'b1, 32'hDEADBEEF, 2'd0, 3, 1'b1, 1'b0, 32'h1FC, acc);
        check("b2b_accept_gap", acc - last_resp_cyc, 32'd2);

        // drain and confirm nothing is left outstanding
        waited = 0;
        while ((exp_q.size() != 0 || wr_addr_q.size() != 0 || exp_addr_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("resp_q_empty",  exp_q.size(), 32'd0);
        check("wr_q_empty",    wr_addr_q.size(), 32'd0);
        check("rdaddr_q_empty", exp_addr_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
